// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3
// codes and the legality/alignment checks applied at request acceptance.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for every legal load/store code.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3[1:0] == 2'b01) mis = addr_lo[0];
        if (funct3[1:0] == 2'b10) mis = (addr_lo != 2'b00);
        return mis;
    endfunction

    function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
        logic ill;
        if (write) ill = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        else       ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        return ill;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges a
// byte/half store into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] merge_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_sel    = rd_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            F3_W:    load_data_o = rd_word_i;
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        store_word_o = merge_word_i;
        case (funct3_i)
            F3_B:    store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H:    store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-only data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic        resp_valid_q;
    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .addr_lo_i    (addr_q[1:0]),
        .rd_word_i    (mem_read_data),
        .merge_word_i (merge_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    assign req_ready      = (state_q == S_IDLE) && !reset;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = rdata_q;
    assign resp_error     = error_q;
    assign mem_read_en    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    // Gating with reset keeps a reset that lands in WRITE from corrupting memory.
    assign mem_wr_en      = (state_q == S_WRITE) && !reset;
    assign mem_address    = (state_q == S_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign mem_write_data = (state_q == S_WRITE) ? store_word : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: only control and visible response registers are reset; the request/merge datapath is always written before use.
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'h0;
                        error_q  <= 1'b0;
                        if (is_illegal(req_write, req_funct3) ||
                            is_misaligned(req_funct3, req_addr[1:0])) begin
                            error_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!req_write) begin
                            state_q <= S_LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q      <= load_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_q <= mem_read_data;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 256-word aliasing data memory
// model; directed transactions carry hand-computed expected responses.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_wr_en;
    logic        mem_read_en;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    resp_t       sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_ctr = 0;
    int          hs_cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    bit          mon_en = 1'b0;

    load_store_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_wr_en      (mem_wr_en),
        .mem_read_en    (mem_read_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;

    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_address[9:2]] <= mem_write_data;
        cyc_ctr <= cyc_ctr + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: strobe bookkeeping, invariants and scoreboard pops.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_wr_en) begin
                wr_cnt++;
                last_wr_addr = mem_address;
                last_wr_data = mem_write_data;
                last_wr_cyc  = cyc_ctr - hs_cyc + 1;
            end
            if (mem_read_en) rd_cnt++;
            check("strobe_exclusive", {31'h0, mem_wr_en & mem_read_en}, 32'h0);
            check("valid_ready_exclusive", {31'h0, resp_valid & req_ready}, 32'h0);
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h with empty scoreboard", resp_rdata);
                end else begin
                    resp_t exp_r;
                    exp_r = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, exp_r.rdata);
                    check("resp_error", {31'h0, resp_error}, {31'h0, exp_r.error});
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_wr_n,
                          input int exp_rd_n, input int exp_wr_cyc,
                          input logic [31:0] exp_wr_data, input int hold);
        int lat;
        int wr0;
        int rd0;
        bit got;
        resp_t e;
        e.rdata = exp_rdata;
        e.error = exp_err;
        sb_q.push_back(e);
        @(posedge clock); #1;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_accept: req_ready never seen for addr 0x%08h", addr);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        hs_cyc = cyc_ctr;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clock);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check("latency", lat, exp_lat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("stall_valid", {31'h0, resp_valid}, 32'h1);
                check("stall_req_ready", {31'h0, req_ready}, 32'h0);
                check("stall_rdata", resp_rdata, exp_rdata);
                @(negedge clock);
            end
            @(posedge clock); #1;
            resp_ready = 1'b1;
            @(negedge clock);
        end
        @(posedge clock); #1;
        check("resp_dropped", {31'h0, resp_valid}, 32'h0);
        check("write_count", wr_cnt - wr0, exp_wr_n);
        check("read_count", rd_cnt - rd0, exp_rd_n);
        if (exp_wr_n > 0) begin
            check("write_addr", last_wr_addr, {addr[31:2], 2'b00});
            check("write_data", last_wr_data, exp_wr_data);
            check("write_cycle", last_wr_cyc, exp_wr_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_strobes", {30'h0, mem_wr_en, mem_read_en}, 32'h0);
        @(posedge clock); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);
        check("idle_mem_address", mem_address, 32'h0);

        // wr f3 addr wdata exp_rdata err lat wr_n rd_n wr_cyc wr_data hold
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 0, 1, 32'hDEADBEEF, 0);
        do_req(0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(1, 3'b010, 32'h20, 32'h11223344, 32'h0,        0, 2, 1, 0, 1, 32'h11223344, 0);
        do_req(1, 3'b000, 32'h22, 32'h000000AB, 32'h0,        0, 3, 1, 1, 2, 32'h11AB3344, 0);
        do_req(0, 3'b000, 32'h22, 32'h0,        32'hFFFFFFAB, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b100, 32'h22, 32'h0,        32'h000000AB, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b010, 32'h20, 32'h0,        32'h11AB3344, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(1, 3'b010, 32'h20, 32'h11223344, 32'h0,        0, 2, 1, 0, 1, 32'h11223344, 0);
        do_req(1, 3'b001, 32'h22, 32'h00008001, 32'h0,        0, 3, 1, 1, 2, 32'h80013344, 0);
        do_req(0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b101, 32'h22, 32'h0,        32'h00008001, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b000, 32'h20, 32'h0,        32'h00000044, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2, 0, 1, 0, 32'h0,        0);
        do_req(0, 3'b001, 32'h20, 32'h0,        32'h00003344, 0, 2, 0, 1, 0, 32'h0,        0);

        // Misaligned and illegal-funct3 requests: error after one cycle, no memory access.
        do_req(0, 3'b010, 32'h21, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        0);
        do_req(1, 3'b001, 32'h23, 32'h1234,     32'h0,        1, 1, 0, 0, 0, 32'h0,        0);
        do_req(0, 3'b011, 32'h20, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        0);
        do_req(1, 3'b100, 32'h20, 32'h55,       32'h0,        1, 1, 0, 0, 0, 32'h0,        0);

        // Back-pressure on a store, then read back through an aliased address.
        do_req(1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0,        0, 2, 1, 0, 1, 32'hCAFEF00D, 5);
        do_req(0, 3'b010, 32'h430, 32'h0,       32'hCAFEF00D, 0, 2, 0, 1, 0, 32'h0,        0);

        // Reset during the RMW read cycle of an SB must abort without a write.
        @(posedge clock); #1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h55;
        @(negedge clock);
        check("rmw_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        wr0 = wr_cnt;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_mid_wr_en", {31'h0, mem_wr_en}, 32'h0);
        check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mid_write_count", wr_cnt - wr0, 0);
        do_req(0, 3'b010, 32'h20, 32'h0,        32'h80013344, 0, 2, 0, 1, 0, 32'h0,        0);

        repeat (2) @(posedge clock);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_mem`. Accepts one memory request at a time over a valid/ready handshake. Performs RV32I byte/halfword/word alignment, sign/zero extension, and misalignment checks. Synthesises sub-word stores as read-modify-write, because `data_mem` only writes whole words; the result is returned on a valid/ready response channel.

## Interface
- No parameters. Word width is fixed at 32. `data_mem` decodes `address[9:2]`, so its address space aliases every 1 KiB.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte/half is used for SB/SH.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_error` out 1: misaligned access or illegal funct3.
- `mem_wr_en` out 1: to `data_mem` `wr_en`.
- `mem_read_en` out 1: to `data_mem` `read_en`.
- `mem_address` out 32: word-aligned address (`req_addr & ~3`).
- `mem_write_data` out 32: full word to write.
- `mem_read_data` in 32: combinational read data from `data_mem`.

## Operation
FSM states are IDLE, LOAD, RMW_RD, WRITE and RESP.
- **IDLE**
  - `req_ready`=1. A handshake occurs when `req_valid` && `req_ready`.
  - On handshake, capture `req_write`, `req_funct3`, `req_addr` and `req_wdata` into registers.
  - Error check: illegal funct3 (loads 011/110/111; stores anything other than 000/001/010), or misalignment (H with `addr[0]`=1; W with `addr[1:0]`≠0). Either sets the error flag and goes to RESP with no memory access.
  - Otherwise the next state is: load → LOAD; SW → WRITE; SB/SH → RMW_RD.
- **LOAD**
  - Drive `mem_read_en`=1 and `mem_address`.
  - Select the lane from `mem_read_data` (byte lane `addr[1:0]`, half lane `addr[1]`), sign- or zero-extend, and register the result into `resp_rdata`.
  - Next state is RESP.
- **RMW_RD**
  - Drive `mem_read_en`=1 and register `mem_read_data` into a merge register.
  - Next state is WRITE.
- **WRITE**
  - `mem_wr_en`=1.
  - `mem_write_data` is one of:
    - `req_wdata` for SW;
    - the merge word with byte lane `addr[1:0]` replaced by `wdata[7:0]`;
    - the merge word with half lane `addr[1]` replaced by `wdata[15:0]`.
  - Next state is RESP.
- **RESP**
  - `resp_valid`=1, with `resp_rdata` and `resp_error` held stable.
  - Move to IDLE when `resp_ready`=1.
- Memory outputs are decoded from the state. `mem_wr_en` and `mem_read_en` are 0 outside their states, and never both 1.
- `mem_address` is driven from the captured address in every non-IDLE state and is 0 in IDLE.

## Timing
- **Reset**
  - After any clock edge with `reset`=1: state is IDLE, and `resp_valid`, `resp_error`, `resp_rdata`, `mem_wr_en` and `mem_read_en` are 0.
  - While `reset`=1, `req_ready`=0.
  - Reset in any state aborts the operation. Reset asserted during WRITE suppresses the write (`mem_wr_en` is gated with `!reset`).
- **Latency**, counted with the handshake edge as cycle 0 (`resp_valid` first high at cycle N):
  - load, N=2;
  - SW, N=2;
  - SB/SH, N=3;
  - error, N=1.
- **Throughput:** there is no overlap. `req_ready`=0 from the cycle after the handshake until the cycle after the RESP handshake.
- **Back-pressure:** RESP holds indefinitely while `resp_ready`=0. The memory write has already occurred and is not repeated.
- `resp_valid` and `req_ready` are never both 1.

## Structure
- `lsu_pkg` holds:
  - the state enum `lsu_state_t`;
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the function `is_misaligned(funct3, addr[1:0])`.
- One combinational sub-module, `lsu_align`, provides load extract/extend and store lane merge. `load_store_unit` holds the FSM and registers.

## Test plan
- **SW then LW:** SW with addr 0x10 and wdata 0xDEADBEEF gives `mem_wr_en` at cycle 1 with `mem_address` 0x10 and the response at cycle 2. A following LW from 0x10 returns `resp_rdata` 0xDEADBEEF, `resp_error`=0.
- **SB merge:** with mem[0x20]=0x11223344, SB at 0x22 with wdata 0xAB gives a read at cycle 1 and a write of 0x11AB3344 at cycle 2. A following LB at 0x22 returns 0xFFFFFFAB and LBU at 0x22 returns 0x000000AB.
- **SH merge:** SH at 0x22 with wdata 0x8001 onto 0x11223344 writes 0x80013344. A following LH at 0x22 returns 0xFFFF8001.
- **Errors:** LW at 0x21, SH at 0x23, and load funct3 011 each give `resp_valid` at cycle 1 with `resp_error`=1, `resp_rdata`=0, and no `mem_wr_en` or `mem_read_en` pulse.
- **Back-pressure:** with `resp_ready` held at 0 for 5 cycles, `resp_valid` and the data stay stable, `req_ready`=0, and exactly one write occurs.
- **Reset mid-RMW:** `reset` asserted during the RMW_RD cycle of an SB gives no write, and after reset is released `req_ready`=1 with `resp_valid`=0.
